conv_window_mac: RTL and testbench
==================================

CONV_WINDOW_MAC -- requirements
Module: conv_window_mac

Interface
REQ-001 The block SHALL have parameter IMG_W, default 6, giving the image row stride in bytes; the value is fixed at 6.
REQ-002 The block SHALL have parameter IMG_H, default 8, giving the number of image rows; legal values are 3..10.
REQ-003 clk  input  1  single clock; all logic SHALL be on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request to begin one full-frame pass; sampled only in IDLE.
REQ-006 weights  input  72  nine signed 8-bit coefficients, packed with w00 at [71:64], row-major, down to w22 at [7:0].
REQ-007 need_Data  output  1  window-fetch request to the pixel RAM.
REQ-008 Needed_Addr  output  6  top-left byte address of the requested window.
REQ-009 data_out  input  96  window returned by the RAM one clock after need_Data is sampled:
- row0 p00..p03 in [95:64];
- row1 p10..p13 in [63:32];
- row2 p20..p23 in [31:0];
- MSB byte first in each row; pixels are unsigned 8-bit.
REQ-010 result  output  42  {res0[41:21], res1[20:0]}; each field is a signed 21-bit sum.
REQ-011 out_valid  output  1  result is valid.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 out_row  output  4  output row index r of the current result.
REQ-014 out_col  output  2  column of res0 (0 or 2); res1 is at out_col+1.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle pulse at end of pass.

Function
REQ-017 The FSM SHALL have the states IDLE, FETCH, LOAD, CALC, OUT and DONE.
REQ-018 In IDLE, start=1 SHALL latch weights, set r=0 and c=0, and move to FETCH; start is ignored in all other states.
REQ-019 FETCH SHALL last one cycle, drive need_Data=1 and Needed_Addr=r*6+c, and move to LOAD; need_Data SHALL be 0 in every other state.
REQ-020 LOAD SHALL last one cycle, register data_out into a 96-bit window register at its end, and move to CALC.
REQ-021 CALC SHALL last one cycle and register both sums into result:
- res0 = sum over i,j in 0..2 of w_ij*p_ij;
- res1 = sum over i,j in 0..2 of w_ij*p_i(j+1);
- each product is a signed 8-bit weight times a zero-extended 8-bit pixel, giving 17 bits signed;
- each sum is formed at 21 bits signed and SHALL NOT overflow or saturate.
CALC then moves to OUT.
REQ-022 OUT SHALL drive out_valid=1, with result, out_row=r and out_col=c held stable, until a cycle with out_ready=1.
REQ-023 On the accepting OUT cycle:
- if c=0: set c=2 and go to FETCH;
- else if r<IMG_H-3: set c=0, increment r, and go to FETCH;
- else: go to DONE.
REQ-024 DONE SHALL assert done=1 for one cycle and return to IDLE.
REQ-025 One pass SHALL produce 2*(IMG_H-2) results, which is 12 for IMG_H=8.
REQ-026 The latency from start accepted to first out_valid SHALL be exactly 4 cycles: the IDLE edge, then FETCH, LOAD, CALC; out_valid is high in the 4th cycle after the start edge.
REQ-027 The back-to-back result interval with out_ready held at 1 SHALL be 4 cycles.
REQ-028 Changes to weights after start is accepted SHALL NOT affect the current pass.
REQ-029 out_valid SHALL NOT drop without a handshake.
REQ-030 The block SHALL NOT drive any RAM write signal; a concurrent RAM write is outside this block's responsibility.

Reset
REQ-031 rst=1 SHALL force IDLE at the next edge, from any state including mid-pass; the pass is abandoned and no done pulse is produced.
REQ-032 Reset values SHALL be need_Data=0, Needed_Addr=0, result=0, out_valid=0, out_row=0, out_col=0, busy=0, done=0, and r, c and the window and weight registers all 0.
REQ-033 If start=1 in the same cycle as rst=1, reset SHALL take priority.

Verification
REQ-034 Identity kernel: RAM byte i=i, w11=1 and all other weights 0, start -> first result is res0=7, res1=8 (r=0, c=0); second result is 9, 10 (c=2); last result is r=5, c=2 with 39, 40; done fires after 12 handshakes.
REQ-035 All-ones kernel, same RAM contents -> first result is res0=63, res1=72, arriving exactly 4 cycles after the start edge.
REQ-036 Sign test: w00=-1 (0xFF) and others 0, all pixels 255 -> res0=res1=-255, i.e. 21-bit 0x1FFF01.
REQ-037 Backpressure: out_ready=0 for 10 cycles at the first result -> out_valid, result and indices stay constant; need_Data stays 0; the pass then proceeds normally.
REQ-038 Reset mid-pass: assert rst during LOAD of the 3rd window -> all outputs go to 0 next cycle; a new start then begins again at r=0, c=0 with Needed_Addr=0.
REQ-039 Start while busy, and weights changed mid-pass -> both are ignored; outputs match REQ-034 exactly.

Source files
------------

// File: rtl/conv_window_mac_if.sv
// Bus bundle for conv_window_mac: start/weights control, pixel-RAM window fetch
// and the valid/ready result channel.
interface conv_window_mac_if;
    logic        start;
    logic [71:0] weights;
    logic        need_Data;
    logic [5:0]  Needed_Addr;
    logic [95:0] data_out;
    logic [41:0] result;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_row;
    logic [1:0]  out_col;
    logic        busy;
    logic        done;

    modport master (
        output start, weights, data_out, out_ready,
        input  need_Data, Needed_Addr, result, out_valid, out_row, out_col, busy, done
    );

    modport slave (
        input  start, weights, data_out, out_ready,
        output need_Data, Needed_Addr, result, out_valid, out_row, out_col, busy, done
    );
endinterface

// File: rtl/conv_window_mac.sv
// 3x3 convolution engine: fetches a 3x4 pixel window per step and produces two
// adjacent signed 21-bit MAC results per handshake, sweeping the frame row by row.
module conv_window_mac #(
    parameter int IMG_W = 6,
    parameter int IMG_H = 8
) (
    input logic               clk,
    input logic               rst,
    conv_window_mac_if.slave  bus
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] FETCH = 3'd1;
    localparam logic [2:0] LOAD  = 3'd2;
    localparam logic [2:0] CALC  = 3'd3;
    localparam logic [2:0] OUT   = 3'd4;
    localparam logic [2:0] DONE  = 3'd5;

    localparam logic [3:0] LAST_ROW = 4'(IMG_H - 3);

    logic [2:0]  state_r;
    logic [2:0]  state_nxt_s;
    logic [3:0]  r_r;
    logic [3:0]  r_nxt_s;
    logic [1:0]  c_r;
    logic [1:0]  c_nxt_s;
    logic [5:0]  addr_nxt_s;
    logic [71:0] weights_r;
    logic [95:0] window_r;
    logic [41:0] res_s;
    logic [41:0] result_r;
    logic [5:0]  addr_r;
    logic        need_data_r;
    logic        out_valid_r;
    logic        busy_r;
    logic        done_r;

    // Signed 8-bit weight times unsigned 8-bit pixel, accumulated at 21 bits;
    // shift selects the window column offset (0 for res0, 1 for res1).
    function automatic logic signed [20:0] dot9(
        input logic [71:0] w,
        input logic [95:0] win,
        input int          shift
    );
        logic signed [20:0] acc;
        logic signed [20:0] wx;
        logic signed [20:0] px;
        acc = 21'sd0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                wx  = {{13{w[71 - 8*(3*i + j)]}}, w[71 - 8*(3*i + j) -: 8]};
                px  = {13'd0, win[95 - 32*i - 8*(j + shift) -: 8]};
                acc = acc + wx * px;
            end
        end
        return acc;
    endfunction

    // Next-state and row/column sequencing
    always_comb begin
        state_nxt_s = state_r;
        r_nxt_s     = r_r;
        c_nxt_s     = c_r;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    state_nxt_s = FETCH;
                    r_nxt_s     = 4'd0;
                    c_nxt_s     = 2'd0;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            FETCH: state_nxt_s = LOAD;
            LOAD:  state_nxt_s = CALC;
            CALC:  state_nxt_s = OUT;
            OUT: begin
                if (bus.out_ready) begin
                    if (c_r == 2'd0) begin
                        c_nxt_s     = 2'd2;
                        state_nxt_s = FETCH;
                    end else if (r_r < LAST_ROW) begin
                        c_nxt_s     = 2'd0;
                        r_nxt_s     = r_r + 4'd1;
                        state_nxt_s = FETCH;
                    end else begin
                        state_nxt_s = DONE;
                    end
                end else begin
                    state_nxt_s = OUT;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Window address and both MAC sums
    always_comb begin
        addr_nxt_s = 6'(int'(r_nxt_s) * IMG_W + int'(c_nxt_s));
        res_s      = {dot9(weights_r, window_r, 0), dot9(weights_r, window_r, 1)};
    end

    // State, indices and outputs, all registered off the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            r_r         <= 4'd0;
            c_r         <= 2'd0;
            addr_r      <= 6'd0;
            need_data_r <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            r_r         <= r_nxt_s;
            c_r         <= c_nxt_s;
            need_data_r <= (state_nxt_s == FETCH);
            out_valid_r <= (state_nxt_s == OUT);
            busy_r      <= (state_nxt_s != IDLE);
            done_r      <= (state_nxt_s == DONE);
            if (state_nxt_s == FETCH) begin
                addr_r <= addr_nxt_s;
            end else begin
                addr_r <= addr_r;
            end
        end
    end

    // Datapath registers: weights snapshot at start, window capture, results
    always_ff @(posedge clk) begin
        if (rst) begin
            weights_r <= 72'd0;
            window_r  <= 96'd0;
            result_r  <= 42'd0;
        end else begin
            if ((state_r == IDLE) && bus.start) begin
                weights_r <= bus.weights;
            end
            if (state_r == LOAD) begin
                window_r <= bus.data_out;
            end
            if (state_r == CALC) begin
                result_r <= res_s;
            end
        end
    end

    assign bus.need_Data   = need_data_r;
    assign bus.Needed_Addr = addr_r;
    assign bus.result      = result_r;
    assign bus.out_valid   = out_valid_r;
    assign bus.out_row     = r_r;
    assign bus.out_col     = c_r;
    assign bus.busy        = busy_r;
    assign bus.done        = done_r;

endmodule

// File: tb/tb_conv_window_mac.sv
// Bench for conv_window_mac: RAM model, arithmetic reference of the 3x3 MAC,
// table of known-answer vectors, directed corner sequences and random passes.
module tb_conv_window_mac;

    localparam int W = 6;
    localparam int H = 8;
    localparam int NRES = 2 * (H - 2);

    logic clk;
    logic rst;
    conv_window_mac_if bus ();

    conv_window_mac #(.IMG_W(W), .IMG_H(H)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    logic [7:0]  mem [64];
    int          n_cmp;
    int          n_err;
    logic [20:0] got0 [NRES];
    logic [20:0] got1 [NRES];
    logic [3:0]  got_row [NRES];
    logic [1:0]  got_col [NRES];

    typedef struct {
        logic [71:0] wts;
        int          mem_mode;
        int          k;
        logic [20:0] e0;
        logic [20:0] e1;
        logic [3:0]  row;
        logic [1:0]  col;
    } vec_t;

    localparam logic [71:0] W_ID   = 72'h00_00_00_00_01_00_00_00_00;
    localparam logic [71:0] W_ONE  = 72'h01_01_01_01_01_01_01_01_01;
    localparam logic [71:0] W_NEG  = 72'hFF_00_00_00_00_00_00_00_00;

    function automatic logic [95:0] ram_window(input logic [5:0] a);
        logic [95:0] v;
        v = 96'd0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 4; j++)
                v[95 - 32*i - 8*j -: 8] = mem[int'(a) + i*W + j];
        return v;
    endfunction

    // Pixel RAM: returns the window one clock after the request is sampled
    always @(posedge clk) begin
        if (rst) bus.data_out <= 96'd0;
        else if (bus.need_Data) bus.data_out <= ram_window(bus.Needed_Addr);
    end

    // Reference: plain sum of weight*pixel read straight from the image
    function automatic int model(input logic [71:0] w, input int r, input int col);
        int s;
        int wv;
        logic [7:0] wb;
        s = 0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                wb = w[71 - 8*(3*i + j) -: 8];
                wv = $signed(wb);
                s += wv * int'(mem[(r + i)*W + col + j]);
            end
        return s;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fill_mem(input int mode);
        for (int i = 0; i < 64; i++) begin
            case (mode)
                0:       mem[i] = 8'(i);
                1:       mem[i] = 8'hFF;
                default: mem[i] = 8'($urandom_range(0, 255));
            endcase
        end
    endtask

    // One full pass; mode 0 ready always, 1 random ready, 2 stall the first result 10 cycles
    task automatic run_pass(input logic [71:0] wts, input int mode, input bit junk);
        int lat;
        int gap;
        int stall;
        int e0;
        int e1;
        int er;
        int ec;
        bit seen;
        bit fin;
        logic [41:0] h_res;
        logic [3:0]  h_row;
        logic [1:0]  h_col;
        logic [95:0] rw;
        bus.weights   = wts;
        bus.start     = 1'b1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        lat = 1;
        gap = 0;
        chk("busy_after_start", {63'd0, bus.busy}, 64'd1);
        for (int k = 0; k < NRES; k++) begin
            er = k / 2;
            ec = (k % 2) * 2;
            e0 = model(wts, er, ec);
            e1 = model(wts, er, ec + 1);
            seen = 1'b0;
            fin = 1'b0;
            stall = 0;
            for (int t = 0; t < 60 && !fin; t++) begin
                bus.start = 1'b0;
                if (bus.need_Data)
                    chk("fetch_addr", {58'd0, bus.Needed_Addr}, 64'(er * W + ec));
                if (bus.out_valid) begin
                    if (!seen) begin
                        chk("res0", {43'd0, bus.result[41:21]}, {43'd0, e0[20:0]});
                        chk("res1", {43'd0, bus.result[20:0]}, {43'd0, e1[20:0]});
                        chk("out_row", {60'd0, bus.out_row}, 64'(er));
                        chk("out_col", {62'd0, bus.out_col}, 64'(ec));
                        if (k == 0) chk("first_latency", 64'(lat), 64'd4);
                        if (mode == 0 && k > 0) chk("result_interval", 64'(gap), 64'd4);
                        got0[k] = bus.result[41:21];
                        got1[k] = bus.result[20:0];
                        got_row[k] = bus.out_row;
                        got_col[k] = bus.out_col;
                        h_res = bus.result;
                        h_row = bus.out_row;
                        h_col = bus.out_col;
                        seen = 1'b1;
                    end else begin
                        chk("hold_result", {22'd0, bus.result}, {22'd0, h_res});
                        chk("hold_idx", {58'd0, bus.out_row, bus.out_col}, {58'd0, h_row, h_col});
                        chk("hold_no_fetch", {63'd0, bus.need_Data}, 64'd0);
                    end
                    case (mode)
                        0:       bus.out_ready = 1'b1;
                        1:       bus.out_ready = 1'($urandom_range(0, 1));
                        default: bus.out_ready = (k != 0) || (stall >= 10);
                    endcase
                    if (bus.out_ready) begin
                        fin = 1'b1;
                        gap = 0;
                    end else begin
                        stall++;
                    end
                end else begin
                    bus.out_ready = 1'($urandom_range(0, 1));
                    if (junk && k < NRES - 1) begin
                        bus.start = 1'($urandom_range(0, 1));
                        rw = {$urandom(), $urandom(), $urandom()};
                        bus.weights = rw[71:0];
                    end
                end
                @(negedge clk);
                lat++;
                gap++;
            end
            if (!fin) chk("valid_timeout", {63'd0, bus.out_valid}, 64'd1);
        end
        bus.out_ready = 1'b0;
        bus.start = 1'b0;
        chk("done_pulse", {62'd0, bus.done, bus.busy}, 64'd3);
        @(negedge clk);
        chk("done_clear", {62'd0, bus.done, bus.busy}, 64'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctl"}, {59'd0, bus.need_Data, bus.out_valid, bus.busy, bus.done, 1'b0}, 64'd0);
        chk({tag, "_addr"}, {58'd0, bus.Needed_Addr}, 64'd0);
        chk({tag, "_result"}, {22'd0, bus.result}, 64'd0);
        chk({tag, "_idx"}, {58'd0, bus.out_row, bus.out_col}, 64'd0);
    endtask

    vec_t vt [6];
    int   nfetch;
    logic [95:0] rw;

    initial begin
        vt[0] = '{W_ID,  0, 0,  21'd7,  21'd8,  4'd0, 2'd0};
        vt[1] = '{W_ID,  0, 1,  21'd9,  21'd10, 4'd0, 2'd2};
        vt[2] = '{W_ID,  0, 11, 21'd39, 21'd40, 4'd5, 2'd2};
        vt[3] = '{W_ONE, 0, 0,  21'd63, 21'd72, 4'd0, 2'd0};
        vt[4] = '{W_NEG, 1, 0,  21'h1FFF01, 21'h1FFF01, 4'd0, 2'd0};
        vt[5] = '{W_NEG, 1, 11, 21'h1FFF01, 21'h1FFF01, 4'd5, 2'd2};

        n_cmp = 0;
        n_err = 0;
        clk = 1'b0;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.weights = 72'd0;
        bus.out_ready = 1'b0;
        fill_mem(0);
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Known-answer vectors
        for (int v = 0; v < 6; v++) begin
            fill_mem(vt[v].mem_mode);
            run_pass(vt[v].wts, 0, 1'b0);
            chk("vec_res0", {43'd0, got0[vt[v].k]}, {43'd0, vt[v].e0});
            chk("vec_res1", {43'd0, got1[vt[v].k]}, {43'd0, vt[v].e1});
            chk("vec_idx", {58'd0, got_row[vt[v].k], got_col[vt[v].k]},
                {58'd0, vt[v].row, vt[v].col});
        end

        // Backpressure on the first result
        fill_mem(0);
        run_pass(W_ID, 2, 1'b0);

        // Start while busy plus weight churn must not disturb the pass
        run_pass(W_ID, 0, 1'b1);
        chk("junk_first", {22'd0, got0[0], got1[0]}, {22'd0, 21'd7, 21'd8});
        chk("junk_last", {22'd0, got0[11], got1[11]}, {22'd0, 21'd39, 21'd40});

        // Reset during LOAD of the third window
        bus.weights = W_ID;
        bus.start = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        nfetch = 0;
        for (int t = 0; t < 60 && nfetch < 3; t++) begin
            if (bus.need_Data) nfetch++;
            if (nfetch < 3) @(negedge clk);
        end
        chk("third_fetch_seen", 64'(nfetch), 64'd3);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b0;
        chk_all_zero("midreset");
        @(negedge clk);
        run_pass(W_ID, 0, 1'b0);

        // Reset wins over a simultaneous start
        rst = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        chk("rst_start_prio", {62'd0, bus.busy, bus.need_Data}, 64'd0);
        rst = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        chk("idle_after_rst", {63'd0, bus.busy}, 64'd0);

        // Random weights and images with random backpressure
        for (int p = 0; p < 6; p++) begin
            fill_mem(2);
            rw = {$urandom(), $urandom(), $urandom()};
            run_pass(rw[71:0], 1, 1'(p % 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
